// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared widths, 3x3 window type and gradient helpers for the
//                Sobel window engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int PIXEL_W    = 8;
    localparam int BUF_ADDR_W = 8;
    localparam int BUF_DATA_W = 16;
    localparam int GRAD_W     = 11;
    localparam int MAG_W      = 12;

    // [row][col]: row 0 is the oldest line (n-2), col 0 is the leftmost column
    typedef logic [2:0][2:0][PIXEL_W-1:0] window_t;

    function automatic logic signed [GRAD_W-1:0] to_grad(input logic [PIXEL_W-1:0] p);
        return $signed({{(GRAD_W-PIXEL_W){1'b0}}, p});
    endfunction

    function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] m;
        m = g[GRAD_W-1] ? -g : g;
        return {1'b0, m};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_gradient.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_gradient
//  Description : Registers Gx/Gy of a 3x3 window, then the saturated (or,
//                with SOBEL_THRESHOLD_EN, binarized) edge magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int THRESHOLD = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_border,
    input  window_t             in_window,
    output logic                out_valid,
    output logic [PIXEL_W-1:0]  out_edge
);

    if (THRESHOLD < 0 || THRESHOLD > 4095) begin : g_bad_threshold
        $error("sobel_gradient: THRESHOLD out of range");
    end

    logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic                     valid2_q, valid2_d, border2_q, border2_d;
    logic                     valid3_q, valid3_d;
    logic [PIXEL_W-1:0]       edge_q, edge_d;
    logic [MAG_W-1:0]         mag;
    logic [PIXEL_W-1:0]       level;

    always_comb begin
        gx_d = (to_grad(in_window[0][2]) + (to_grad(in_window[1][2]) <<< 1) + to_grad(in_window[2][2]))
             - (to_grad(in_window[0][0]) + (to_grad(in_window[1][0]) <<< 1) + to_grad(in_window[2][0]));
        gy_d = (to_grad(in_window[2][0]) + (to_grad(in_window[2][1]) <<< 1) + to_grad(in_window[2][2]))
             - (to_grad(in_window[0][0]) + (to_grad(in_window[0][1]) <<< 1) + to_grad(in_window[0][2]));
        valid2_d  = in_valid;
        border2_d = in_border;
    end

    always_comb begin
        mag = abs_grad(gx_q) + abs_grad(gy_q);
`ifdef SOBEL_THRESHOLD_EN
        level = (mag >= MAG_W'(THRESHOLD)) ? {PIXEL_W{1'b1}} : '0;
`else
        level = (mag > MAG_W'(255)) ? {PIXEL_W{1'b1}} : mag[PIXEL_W-1:0];
`endif
        valid3_d = valid2_q;
        edge_d   = (valid2_q && !border2_q) ? level : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gx_q      <= '0;
            gy_q      <= '0;
            valid2_q  <= 1'b0;
            border2_q <= 1'b0;
            valid3_q  <= 1'b0;
            edge_q    <= '0;
        end else begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            valid2_q  <= valid2_d;
            border2_q <= border2_d;
            valid3_q  <= valid3_d;
            edge_q    <= edge_d;
        end
    end

    assign out_valid = valid3_q;
    assign out_edge  = edge_q;

endmodule
`default_nettype wire

// File: rtl/sobel_window_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_engine
//  Description : Raster-stream Sobel edge engine driving a 256x16 line buffer.
//                Optional build macro SOBEL_THRESHOLD_EN binarizes the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_engine
    import sobel_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int THRESHOLD  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pixelValid,
    input  logic [PIXEL_W-1:0]      pixelIn,
    input  logic                    newLine,
    input  logic                    newFrame,
    output logic [BUF_ADDR_W-1:0]   bufAddrRd,
    output logic [BUF_ADDR_W-1:0]   bufAddrWr,
    output logic                    bufWe,
    output logic [BUF_DATA_W-1:0]   bufWrData,
    input  logic [BUF_DATA_W-1:0]   bufRdData,
    output logic                    edgeValid,
    output logic [PIXEL_W-1:0]      edgeOut
);

    if (LINE_WIDTH < 4 || LINE_WIDTH > 256) begin : g_bad_line_width
        $error("sobel_window_engine: LINE_WIDTH out of range");
    end

    // One spare bit so the column can sit at LINE_WIDTH while trailing pixels are dropped
    localparam int               COL_W     = BUF_ADDR_W + 1;
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(LINE_WIDTH);

    logic [COL_W-1:0]       col_q, col_d, pix_col;
    logic [1:0]             row_q, row_d, pix_row;
    logic                   accept;
    logic                   s0_valid_q, s0_valid_d;
    logic                   s0_border_q, s0_border_d;
    logic [PIXEL_W-1:0]     s0_pix_q, s0_pix_d;
    logic [BUF_ADDR_W-1:0]  s0_col_q, s0_col_d;
    window_t                window_q, window_d;

    always_comb begin
        pix_col = col_q;
        pix_row = row_q;
        if (pixelValid && newLine) begin
            pix_col = '0;
            if (newFrame) begin
                pix_row = '0;
            end else if (row_q != 2'd2) begin
                pix_row = row_q + 2'd1;
            end
        end
        accept      = pixelValid && (pix_col < COL_LIMIT);
        col_d       = accept ? pix_col + COL_W'(1) : col_q;
        row_d       = pixelValid ? pix_row : row_q;
        s0_valid_d  = accept;
        s0_pix_d    = accept ? pixelIn : s0_pix_q;
        s0_col_d    = accept ? pix_col[BUF_ADDR_W-1:0] : s0_col_q;
        s0_border_d = (pix_row < 2'd2) || (pix_col < COL_W'(2));
        bufAddrRd   = accept ? pix_col[BUF_ADDR_W-1:0] : '0;
    end

    // Stage 1: read data for this column has arrived; write back and shift the window
    always_comb begin
        window_d  = window_q;
        bufWe     = s0_valid_q;
        bufAddrWr = s0_valid_q ? s0_col_q : '0;
        bufWrData = s0_valid_q ? {bufRdData[PIXEL_W-1:0], s0_pix_q} : '0;
        if (s0_valid_q) begin
            for (int r = 0; r < 3; r++) begin
                window_d[r][0] = window_q[r][1];
                window_d[r][1] = window_q[r][2];
            end
            window_d[0][2] = bufRdData[BUF_DATA_W-1:PIXEL_W];
            window_d[1][2] = bufRdData[PIXEL_W-1:0];
            window_d[2][2] = s0_pix_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            s0_valid_q  <= 1'b0;
            s0_border_q <= 1'b0;
            s0_pix_q    <= '0;
            s0_col_q    <= '0;
            window_q    <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s0_valid_q  <= s0_valid_d;
            s0_border_q <= s0_border_d;
            s0_pix_q    <= s0_pix_d;
            s0_col_q    <= s0_col_d;
            window_q    <= window_d;
        end
    end

    // Fed with the freshly shifted window so the edge lands three cycles after acceptance
    sobel_gradient #(
        .THRESHOLD (THRESHOLD)
    ) u_gradient (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s0_valid_q),
        .in_border (s0_border_q),
        .in_window (window_d),
        .out_valid (edgeValid),
        .out_edge  (edgeOut)
    );

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_window_engine
//  Description : Scoreboard bench for sobel_window_engine with a line buffer
//                model; honours SOBEL_THRESHOLD_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_engine;

    localparam int LW  = 16;
    localparam int THR = 64;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        pixelValid = 1'b0;
    logic [7:0]  pixelIn    = 8'd0;
    logic        newLine    = 1'b0;
    logic        newFrame   = 1'b0;
    logic [7:0]  bufAddrRd, bufAddrWr;
    logic        bufWe;
    logic [15:0] bufWrData;
    logic [15:0] bufRdData;
    logic        edgeValid;
    logic [7:0]  edgeOut;

    sobel_window_engine #(
        .LINE_WIDTH (LW),
        .THRESHOLD  (THR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pixelValid (pixelValid),
        .pixelIn    (pixelIn),
        .newLine    (newLine),
        .newFrame   (newFrame),
        .bufAddrRd  (bufAddrRd),
        .bufAddrWr  (bufAddrWr),
        .bufWe      (bufWe),
        .bufWrData  (bufWrData),
        .bufRdData  (bufRdData),
        .edgeValid  (edgeValid),
        .edgeOut    (edgeOut)
    );

    always #5 clock = ~clock;

    // Line buffer: registered read, write on the same clock
    logic [15:0] mem [256];
    always @(posedge clock) begin
        if (bufWe) mem[bufAddrWr] <= bufWrData;
        bufRdData <= mem[bufAddrRd];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
        int aux;
    } exp_t;

    exp_t eq[$];
    exp_t wq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_edges  = 0;

    logic [7:0] img [16][256];
    int         b_row = 0;
    int         b_col = 0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int lvl(int mag);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= THR) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    function automatic int px(int r, int c);
        return int'(img[r][c]);
    endfunction

    function automatic int sobel_ref(int r, int c);
        int gx, gy;
        gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
        gy = (px(r,c-2) + 2*px(r,c-1) + px(r,c)) - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return lvl(gx + gy);
    endfunction

    // Monitor: edge outputs and buffer writes against the scoreboard queues
    always @(negedge clock) begin
        exp_t e;
        if (edgeValid) begin
            n_edges++;
            if (eq.size() == 0) begin
                check("unexpected_edge", 1, 0);
            end else begin
                e = eq.pop_front();
                check("edge_latency", cyc, e.due);
                check("edge_value", int'(edgeOut), e.val);
            end
        end else if (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            check("missing_edge", 0, 1);
        end
        if (bufWe) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = wq.pop_front();
                check("wr_cycle", cyc, e.due);
                check("wr_addr", int'(bufAddrWr), e.val);
                check("wr_data_pixel", int'(bufWrData[7:0]), e.aux);
            end
        end else if (wq.size() > 0 && wq[0].due <= cyc) begin
            e = wq.pop_front();
            check("missing_write", 0, 1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            pixelValid = 1'b0;
            newLine    = 1'b0;
            newFrame   = 1'b0;
        end
    endtask

    // hand_mag < 0 selects the reference model for the expected value
    task automatic send(input int pix, input bit nl, input bit nf, input int hand_mag);
        int exp_v;
        @(negedge clock);
        if (nl) begin
            b_col = 0;
            b_row = nf ? 0 : b_row + 1;
        end
        pixelValid = 1'b1;
        pixelIn    = 8'(pix);
        newLine    = nl;
        newFrame   = nf;
        if (b_col < LW) begin
            img[b_row][b_col] = 8'(pix);
            if (b_row < 2 || b_col < 2) exp_v = 0;
            else if (hand_mag >= 0)     exp_v = lvl(hand_mag);
            else                        exp_v = sobel_ref(b_row, b_col);
            eq.push_back('{exp_v, cyc + 3, 0});
            wq.push_back('{b_col, cyc + 1, pix & 255});
            #1 check("rd_addr", int'(bufAddrRd), b_col);
            b_col++;
        end
    endtask

    // kind: 0 uniform, 1 step 0/255, 2 step 0/10, 3 textured
    task automatic frame(input int kind, input int rows, input bit gaps, input int extra);
        int pix, hand;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < LW + extra; c++) begin
                if (gaps) begin
                    while ($urandom_range(0, 1) == 1) idle(1);
                end
                case (kind)
                    0: begin pix = 100;                hand = 0; end
                    1: begin pix = (c < 8) ? 0 : 255;  hand = (c == 8 || c == 9) ? 1020 : 0; end
                    2: begin pix = (c < 8) ? 0 : 10;   hand = (c == 8 || c == 9) ? 40 : 0; end
                    default: begin pix = (r*53 + c*c*7 + c*19) & 255; hand = -1; end
                endcase
                send(pix, c == 0, r == 0 && c == 0, hand);
            end
        end
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        repeat (3) @(negedge clock);
        check("reset_edgeValid", int'(edgeValid), 0);
        check("reset_edgeOut", int'(edgeOut), 0);
        check("reset_bufWe", int'(bufWe), 0);
        check("reset_bufAddrWr", int'(bufAddrWr), 0);
        check("reset_bufWrData", int'(bufWrData), 0);
        check("reset_bufAddrRd", int'(bufAddrRd), 0);
        reset = 1'b0;

        e0 = n_edges;
        frame(0, 4, 1'b0, 0);
        idle(6);
        check("uniform_edge_count", n_edges - e0, 4 * LW);

        frame(1, 4, 1'b0, 0);
        frame(2, 4, 1'b0, 0);
        frame(1, 4, 1'b1, 0);

        // Textured frame cut short by newFrame at line 3, with trailing dropped pixels
        frame(3, 3, 1'b0, 3);
        frame(3, 3, 1'b0, 0);
        idle(6);

        // Reset with three pixels in flight
        send(10, 1'b1, 1'b0, -1);
        send(20, 1'b0, 1'b0, -1);
        send(30, 1'b0, 1'b0, -1);
        @(negedge clock);
        reset      = 1'b1;
        pixelValid = 1'b0;
        newLine    = 1'b0;
        newFrame   = 1'b0;
        while (eq.size() > 0 && eq[$].due > cyc) void'(eq.pop_back());
        while (wq.size() > 0 && wq[$].due > cyc) void'(wq.pop_back());
        repeat (3) begin
            @(negedge clock);
            check("midreset_edgeValid", int'(edgeValid), 0);
            check("midreset_bufWe", int'(bufWe), 0);
        end
        reset = 1'b0;
        b_row = 0;
        b_col = 0;
        frame(3, 4, 1'b0, 0);

        idle(8);
        check("scoreboard_drained", eq.size() + wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_window_engine.md
Name: sobel_window_engine

Overview:
Downstream consumer of the 256x16 Sobel line buffer, on a single clock domain. Accepts a raster stream of 8-bit grayscale pixels and drives the line buffer's read and write ports. Each buffer entry packs two pixels for one column: {row n-2, row n-1}. The engine builds a 3x3 window, computes |Gx|+|Gy| and emits one saturated 8-bit edge value per accepted pixel, feeding the camera edge/motion path.

Parameters:
LINE_WIDTH, 256, active pixels per line; legal range 4..256, matching buffer depth.
THRESHOLD, 64, binarization level; used only with SOBEL_THRESHOLD_EN.

Ports:
clock  in  1  system clock; line buffer runs on this same clock for both ports.
reset  in  1  synchronous, active-high.
pixelValid  in  1  pixelIn qualifier.
pixelIn  in  8  grayscale pixel.
newLine  in  1  with pixelValid: this pixel is column 0 of a new line.
newFrame  in  1  with pixelValid and newLine: first pixel of a frame.
bufAddrRd  out  8  line buffer read address.
bufAddrWr  out  8  line buffer write address.
bufWe  out  1  line buffer write enable.
bufWrData  out  16  {previous row n-1 pixel, current pixel}.
bufRdData  in  16  registered read data, valid 1 cycle after bufAddrRd.
edgeValid  out  1  edgeOut qualifier.
edgeOut  out  8  edge magnitude for window centre (row-1, col-1).

Behaviour:
- Reset: all outputs 0; column = 0, row = 0; window and pipeline valids cleared. Reset asserted mid-stream gives edgeValid=0 from the next edge and discards in-flight pixels. Buffer contents are not cleared; the row counter masks them.
- Column counter:
  - Set to 0 when pixelValid and newLine are both high.
  - Otherwise increments per accepted pixel.
  - Pixels at column >= LINE_WIDTH are dropped: no read, no write, no output.
- Row counter:
  - Cleared by newFrame.
  - Incremented on each newLine that is not a newFrame.
  - Saturates at 2 (it is only a border flag).
- Stage 0 (cycle t): bufAddrRd = column, combinational from the accepted pixel. Pixel, column and border flags are registered.
- Stage 1 (t+1):
  - bufRdData = {p[r-2], p[r-1]} for this column.
  - Write back bufWe=1, bufAddrWr = stage-1 column, bufWrData = {bufRdData[7:0], pixel}.
  - The 3x3 window shifts left by one column; the new column is {bufRdData[15:8], bufRdData[7:0], pixel}.
  - Read and write addresses in the same cycle always differ because consecutive accepted pixels have distinct columns. This is why LINE_WIDTH >= 4.
- Stage 2 (t+2): registered signed 11-bit gradients.
  - Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20).
  - Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02).
- Stage 3 (t+3): mag = |Gx| + |Gy|, 12 bits, maximum 2040. edgeOut = min(mag, 255). edgeValid = 1.
- Latency: exactly 3 cycles from the accepted pixel. Bubbles in pixelValid propagate as edgeValid=0; there is no back-pressure.
- Border: edgeOut is forced to 0 (edgeValid still 1) when row < 2 or column < 2 at acceptance.
- Window state holds across pixelValid gaps. A newLine mid-line truncates that line with no error.

Optional Feature:
SOBEL_THRESHOLD_EN
- Defined: the stage-3 output is binarized. edgeOut = 255 if mag >= THRESHOLD, else 0. Border pixels remain 0.
- Undefined: edgeOut is the saturated magnitude and the THRESHOLD parameter is ignored.
- Latency is identical in both builds.

Decomposition:
- Shared package sobel_pkg:
  - PIXEL_W = 8, BUF_ADDR_W = 8, BUF_DATA_W = 16, GRAD_W = 11, MAG_W = 12.
  - Typedef for the 3x3 window (nine pixels).
- One natural sub-module, sobel_gradient: takes the window and border flag, registers Gx/Gy, then the saturated or thresholded magnitude (stages 2-3).
- Counters, buffer port control and window shifting stay in the top.

Test Plan:
- Uniform frame, all pixels 100, LINE_WIDTH=16, 4 lines: rows 0-1 give edgeOut 0; interior gives 0. edgeValid count = 64, each exactly 3 cycles after its pixel.
- Vertical step (columns 0-7 = 0, columns 8-15 = 255), rows >= 2: centres at columns 7 and 8 give Gx = 1020, so edgeOut = 255; all other columns give 0.
- Vertical step of 10 (0 -> 10): edgeOut = 40 at step centres. With SOBEL_THRESHOLD_EN and THRESHOLD=64: 0. With THRESHOLD=40: 255.
- Random pixelValid gaps (50% duty) on the step image: edgeOut sequence matches the gap-free run. Each bufWe cycle has bufAddrWr equal to the previous cycle's bufAddrRd.
- newFrame asserted at the start of line 3 of a textured frame: the next two lines output only 0. Pixels at column >= LINE_WIDTH produce no bufWe and no edgeValid.
- reset pulsed while 3 pixels are in flight: edgeValid = 0 from the next edge. After release, the first two rows of the new frame output 0.
